dice_game_ctrl: RTL
===================

# dice_game_ctrl

Match sequencer for the dual-dice comparator datapath. It free-runs two pseudo-random dice-pair generators and captures one pair per player on a roll press. It drives the captured values into the adder/comparator datapath and samples its greater/equal/less result. It keeps per-player scores and declares a match winner at WIN_SCORE points.

## Interface
- WIN_SCORE, 3: points needed to win the match; legal range 1..7.
- SHOW_CYCLES, 4: cycles the round result is held in S_SHOW; legal range ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a match from S_IDLE or S_DONE; level sampled.
- roll_a  in  1  player A roll button, debounced; rising edge acts.
- roll_b  in  1  player B roll button, debounced; rising edge acts.
- cmp  in  [0:2]  datapath result {gt, eq, lt}, sumA vs sumB; combinational from a..d.
- a, b  out  [0:2]  player A captured dice, MSB-first, to datapath.
- c, d  out  [0:2]  player B captured dice, MSB-first, to datapath.
- res  out  [0:2]  registered round result {gt, eq, lt}.
- score_a, score_b  out  [0:2]  match scores.
- a_done, b_done  out  1  player has captured this round.
- rolling  out  1  state is S_ROLL.
- game_over  out  1  state is S_DONE.
- winner  out  1  0 = A, 1 = B; valid only when game_over=1.

## Operation
- Reset values:
  - State S_IDLE.
  - a, b, c, d, res, score_a, score_b = 0.
  - a_done, b_done, rolling, game_over, winner = 0.
  - Edge-detect registers roll_a_q, roll_b_q = 0.
  - Generators g0 = g1 = 1, g2 = g3 = 6.
- Generators update every non-reset cycle, in all states:
  - g0: 1→2→…→6→1.
  - g1: steps the same way only on cycles where g0 = 6.
  - g2: 6→5→…→1→6.
  - g3: steps the same way only on cycles where g2 = 1.
- Edge detect: roll_x_e = roll_x & ~roll_x_q. A held button counts once.
- S_IDLE: start=1 → S_ROLL.
- S_ROLL, capture:
  - roll_a_e with a_done=0: a←g0, b←g1, a_done←1.
  - roll_b_e with b_done=0: c←g2, d←g3, b_done←1.
  - Both edges in the same cycle: both players capture.
  - Edges after a player is done, and edges in any other state: ignored.
- S_ROLL, exit: the edge that makes both done flags 1 also moves the state to S_CMP.
- S_CMP (exactly 1 cycle), samples cmp:
  - 100: score_a+1.
  - 001: score_b+1.
  - 010, or any non-one-hot value: treated as a tie, no score, res←010.
  - Otherwise res←cmp.
  - Clears a_done and b_done.
  - Next state S_SHOW. The show counter loads SHOW_CYCLES-1.
- S_SHOW: counts down to 0, then:
  - A score equal to WIN_SCORE → S_DONE, with winner set to that player.
  - Otherwise → S_ROLL, with res←000.
  - a..d hold until the next capture.
- Scores never exceed WIN_SCORE. Both scores cannot reach it in the same round.
- S_DONE: outputs frozen. start=1 → S_ROLL with these cleared: scores, res, a..d, winner, game_over.
- rst in any state overrides everything and restores the reset values on the next edge.

## Timing
- Edge N is the N-th rising edge with rst=0. It samples g0 = ((N-1) mod 6)+1 and g2 = 6-((N-1) mod 6).
- Capture latency: a roll edge sampled at edge N makes its dice visible on a..d after edge N.
- Round latency, with the second capture at edge N:
  - S_CMP during cycle N→N+1.
  - score and res update at edge N+1.
  - S_SHOW spans edges N+1 to N+1+SHOW_CYCLES.
  - S_ROLL or S_DONE from edge N+1+SHOW_CYCLES.
- The datapath is combinational from registered a..d. cmp is stable by S_CMP; no handshake is needed.
- rolling and game_over are decoded from the state register. They are never early.

## Test plan
- Reset and capture:
  - Stimulus: start=1 at edge 1; roll_a rises at edge 3; roll_b rises at edge 4.
  - Required: after edge 3, a=3, b=1, a_done=1; after edge 4, c=3, d=6.
  - With cmp=001 driven: after edge 5, res=001 and score_b=1; rolling=1 again after edge 9.
- Tie and invalid cmp:
  - Round 1 with cmp=010; round 2 with cmp=110.
  - Required: res=010 both times, scores unchanged.
- Held button:
  - roll_a held high for 20 cycles in S_ROLL.
  - Required: a and b captured once, unchanged afterwards; no second capture in the next round until roll_a falls and rises again.
- Simultaneous rolls: roll_a and roll_b rise at the same edge → both captured, and S_CMP follows on the next cycle.
- Match end, WIN_SCORE=3:
  - Three rounds with cmp=100.
  - Required: score_a=3, game_over=1, winner=0; further rolls ignored.
  - start=1 → scores 0, rolling=1.
- Reset mid-round: rst asserted in S_SHOW with score_a=2 → all outputs return to reset values one edge later; state S_IDLE.

Source files
------------

// File: rtl/dice_game_ctrl.sv
// Match sequencer for the dual-dice comparator: free-running dice generators,
// per-player capture on roll edges, round scoring and match-winner detection.
module dice_game_ctrl #(
    parameter int WIN_SCORE   = 3,
    parameter int SHOW_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       roll_a,
    input  logic       roll_b,
    input  logic [0:2] cmp,
    output logic [0:2] a,
    output logic [0:2] b,
    output logic [0:2] c,
    output logic [0:2] d,
    output logic [0:2] res,
    output logic [0:2] score_a,
    output logic [0:2] score_b,
    output logic       a_done,
    output logic       b_done,
    output logic       rolling,
    output logic       game_over,
    output logic       winner
);

    localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ROLL = 3'd1;
    localparam logic [2:0] S_CMP  = 3'd2;
    localparam logic [2:0] S_SHOW = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] WIN = 3'(WIN_SCORE);

    logic [2:0]       state_q, state_d;
    logic [2:0]       g0_q, g0_d, g1_q, g1_d, g2_q, g2_d, g3_q, g3_d;
    logic             roll_a_q, roll_b_q;
    logic             roll_a_e, roll_b_e;
    logic [2:0]       a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [2:0]       res_q, res_d;
    logic [2:0]       score_a_q, score_a_d, score_b_q, score_b_d;
    logic             a_done_q, a_done_d, b_done_q, b_done_d;
    logic             winner_q, winner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [2:0] up6(input logic [2:0] v);
        return (v == 3'd6) ? 3'd1 : v + 3'd1;
    endfunction

    function automatic logic [2:0] down6(input logic [2:0] v);
        return (v == 3'd1) ? 3'd6 : v - 3'd1;
    endfunction

    // Two odometer-style counters: g1/g3 advance when their partner wraps.
    always_comb begin
        g0_d = up6(g0_q);
        g1_d = (g0_q == 3'd6) ? up6(g1_q) : g1_q;
        g2_d = down6(g2_q);
        g3_d = (g2_q == 3'd1) ? down6(g3_q) : g3_q;
    end

    assign roll_a_e = roll_a & ~roll_a_q;
    assign roll_b_e = roll_b & ~roll_b_q;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        d_d       = d_q;
        res_d     = res_q;
        score_a_d = score_a_q;
        score_b_d = score_b_q;
        a_done_d  = a_done_q;
        b_done_d  = b_done_q;
        winner_d  = winner_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ROLL;
            end
            S_ROLL: begin
                if (roll_a_e && !a_done_q) begin
                    a_d      = g0_q;
                    b_d      = g1_q;
                    a_done_d = 1'b1;
                end
                if (roll_b_e && !b_done_q) begin
                    c_d      = g2_q;
                    d_d      = g3_q;
                    b_done_d = 1'b1;
                end
                if (a_done_d && b_done_d) state_d = S_CMP;
            end
            S_CMP: begin
                // Anything that is not a clean win for one side scores as a tie.
                case (cmp)
                    3'b100: begin
                        res_d = cmp;
                        if (score_a_q < WIN) score_a_d = score_a_q + 3'd1;
                    end
                    3'b001: begin
                        res_d = cmp;
                        if (score_b_q < WIN) score_b_d = score_b_q + 3'd1;
                    end
                    default: res_d = 3'b010;
                endcase
                a_done_d = 1'b0;
                b_done_d = 1'b0;
                cnt_d    = CNT_W'(SHOW_CYCLES - 1);
                state_d  = S_SHOW;
            end
            S_SHOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (score_a_q == WIN) begin
                    winner_d = 1'b0;
                    state_d  = S_DONE;
                end else if (score_b_q == WIN) begin
                    winner_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    res_d   = 3'b000;
                    state_d = S_ROLL;
                end
            end
            S_DONE: begin
                if (start) begin
                    score_a_d = '0;
                    score_b_d = '0;
                    res_d     = '0;
                    a_d       = '0;
                    b_d       = '0;
                    c_d       = '0;
                    d_d       = '0;
                    winner_d  = 1'b0;
                    state_d   = S_ROLL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            g0_q      <= 3'd1;
            g1_q      <= 3'd1;
            g2_q      <= 3'd6;
            g3_q      <= 3'd6;
            roll_a_q  <= 1'b0;
            roll_b_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            res_q     <= '0;
            score_a_q <= '0;
            score_b_q <= '0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            winner_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            g0_q      <= g0_d;
            g1_q      <= g1_d;
            g2_q      <= g2_d;
            g3_q      <= g3_d;
            roll_a_q  <= roll_a;
            roll_b_q  <= roll_b;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            d_q       <= d_d;
            res_q     <= res_d;
            score_a_q <= score_a_d;
            score_b_q <= score_b_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
            winner_q  <= winner_d;
            cnt_q     <= cnt_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign c         = c_q;
    assign d         = d_q;
    assign res       = res_q;
    assign score_a   = score_a_q;
    assign score_b   = score_b_q;
    assign a_done    = a_done_q;
    assign b_done    = b_done_q;
    assign winner    = winner_q;
    assign rolling   = (state_q == S_ROLL);
    assign game_over = (state_q == S_DONE);

endmodule
